// File: rtl/alu_op_issue.sv
// alu_op_issue: issue/writeback sequencer for the combinational 32-bit ALU.
//
// Accepts one RV32 R-type (0110011) or I-type (0010011) integer instruction
// plus its operands over a valid/ready handshake. It decodes the instruction
// into the ALU's 3-bit opcode and drives registered operands to the ALU. It
// captures the ALU result and zero flag, then presents them toward writeback
// over a valid/ready handshake.
//
// Ports:
//   clk, reset                  clock, asynchronous active-high reset
//   in_valid/in_ready           instruction beat handshake
//   instr, rs1_val, rs2_val     instruction word and source operands
//   alu_in1, alu_in2            registered ALU operands
//   alu_control                 registered ALU opcode (000 for illegal)
//   alu_result, zero_flag       combinational ALU outputs
//   out_valid/out_ready         result beat handshake
//   out_result, out_zero        captured result / zero flag (0 for illegal)
//   out_rd                      destination register instr[11:7]
//   out_illegal                 instruction not supported by the ALU
//
// Optional feature (macro ALU_ISSUE_PERF_EN): adds wrapping 32-bit counters
// perf_issued (every accepted beat) and perf_illegal (every accepted illegal beat).
module alu_op_issue #(
  parameter int unsigned XLEN = 32  // only 32 is supported
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [31:0]     instr,
  input  logic [XLEN-1:0] rs1_val,
  input  logic [XLEN-1:0] rs2_val,
  output logic [XLEN-1:0] alu_in1,
  output logic [XLEN-1:0] alu_in2,
  output logic [2:0]      alu_control,
  input  logic [XLEN-1:0] alu_result,
  input  logic            zero_flag,
  output logic            out_valid,
  input  logic            out_ready,
  output logic [XLEN-1:0] out_result,
  output logic            out_zero,
  output logic [4:0]      out_rd,
  output logic            out_illegal
`ifdef ALU_ISSUE_PERF_EN
  ,
  output logic [31:0]     perf_issued,
  output logic [31:0]     perf_illegal
`endif
);

  typedef enum logic [1:0] {StIdle, StExec, StDone} state_e;

  state_e          state_q, state_d;
  logic [XLEN-1:0] alu_in1_q, alu_in2_q, result_q;
  logic [2:0]      ctrl_q;
  logic            zero_q, illegal_q;
  logic [4:0]      rd_q;

  // Decode
  logic            is_r, is_i, f7_ok;
  logic            dec_legal;
  logic [2:0]      dec_ctrl;
  logic [XLEN-1:0] dec_in2;
  logic            accept;

  // rs1/rs2 register indices are not needed; operands arrive by value.
  logic unused_instr;
  assign unused_instr = ^instr[19:15];

  always_comb begin
    is_r      = (instr[6:0] == 7'b0110011);
    is_i      = (instr[6:0] == 7'b0010011);
    f7_ok     = (instr[31:25] == 7'b0000000) || (instr[31:25] == 7'b0100000);
    dec_legal = 1'b0;
    dec_ctrl  = 3'b000;
    dec_in2   = is_i ? {{(XLEN-12){instr[31]}}, instr[31:20]} : rs2_val;
    if ((is_r && f7_ok) || is_i) begin
      dec_legal = 1'b1;
      case (instr[14:12])
        3'b000:         dec_ctrl = (is_r && instr[30]) ? 3'b001 : 3'b000; // I-type ignores bit 30
        3'b111:         dec_ctrl = 3'b010;
        3'b110:         dec_ctrl = 3'b011;
        3'b100:         dec_ctrl = 3'b100;
        3'b010, 3'b011: dec_ctrl = 3'b101;
        default: begin
          dec_legal = 1'b0;  // shifts (001/101)
          dec_ctrl  = 3'b000;
        end
      endcase
    end
  end

  assign accept = (state_q == StIdle) && in_valid;

  // FSM
  always_ff @(posedge clk or posedge reset) begin
    if (reset) state_q <= StIdle;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: if (in_valid) state_d = dec_legal ? StExec : StDone;
      StExec: state_d = StDone;
      StDone: if (out_ready) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      alu_in1_q <= '0;
      alu_in2_q <= '0;
      ctrl_q    <= 3'b000;
      result_q  <= '0;
      zero_q    <= 1'b0;
      rd_q      <= 5'd0;
      illegal_q <= 1'b0;
    end else if (accept) begin
      alu_in1_q <= rs1_val;
      alu_in2_q <= dec_in2;
      ctrl_q    <= dec_ctrl;
      rd_q      <= instr[11:7];
      illegal_q <= ~dec_legal;
      // Illegal goes straight to DONE, so the zeroed result is what retires.
      result_q  <= '0;
      zero_q    <= 1'b0;
    end else if (state_q == StExec) begin
      result_q  <= alu_result;
      zero_q    <= zero_flag;
    end
  end

`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued_q, perf_illegal_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      perf_issued_q  <= 32'd0;
      perf_illegal_q <= 32'd0;
    end else if (accept) begin
      perf_issued_q <= perf_issued_q + 32'd1;
      if (!dec_legal) perf_illegal_q <= perf_illegal_q + 32'd1;
    end
  end

  assign perf_issued  = perf_issued_q;
  assign perf_illegal = perf_illegal_q;
`endif

  assign in_ready    = (state_q == StIdle);
  assign out_valid   = (state_q == StDone);
  assign alu_in1     = alu_in1_q;
  assign alu_in2     = alu_in2_q;
  assign alu_control = ctrl_q;
  assign out_result  = result_q;
  assign out_zero    = zero_q;
  assign out_rd      = rd_q;
  assign out_illegal = illegal_q;

endmodule

// File: tb/tb_alu_op_issue.sv
module tb_alu_op_issue;

  logic        clk = 1'b0;
  logic        reset;
  logic        in_valid, in_ready;
  logic [31:0] instr, rs1_val, rs2_val;
  logic [31:0] alu_in1, alu_in2;
  logic [2:0]  alu_control;
  logic [31:0] alu_result;
  logic        zero_flag;
  logic        out_valid, out_ready;
  logic [31:0] out_result;
  logic        out_zero;
  logic [4:0]  out_rd;
  logic        out_illegal;
`ifdef ALU_ISSUE_PERF_EN
  logic [31:0] perf_issued, perf_illegal;
  int unsigned exp_issued = 0, exp_illegal = 0;
`endif

  always #5 clk = ~clk;

  alu_op_issue dut (
    .clk         (clk),
    .reset       (reset),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .instr       (instr),
    .rs1_val     (rs1_val),
    .rs2_val     (rs2_val),
    .alu_in1     (alu_in1),
    .alu_in2     (alu_in2),
    .alu_control (alu_control),
    .alu_result  (alu_result),
    .zero_flag   (zero_flag),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .out_result  (out_result),
    .out_zero    (out_zero),
    .out_rd      (out_rd),
    .out_illegal (out_illegal)
`ifdef ALU_ISSUE_PERF_EN
    ,
    .perf_issued (perf_issued),
    .perf_illegal(perf_illegal)
`endif
  );

  // Behavioural ALU attached to the DUT (sub returns |in1-in2|, slt unsigned)
  always_comb begin
    case (alu_control)
      3'b000:  alu_result = alu_in1 + alu_in2;
      3'b001:  alu_result = (alu_in1 >= alu_in2) ? alu_in1 - alu_in2 : alu_in2 - alu_in1;
      3'b010:  alu_result = alu_in1 & alu_in2;
      3'b011:  alu_result = alu_in1 | alu_in2;
      3'b100:  alu_result = alu_in1 ^ alu_in2;
      3'b101:  alu_result = (alu_in1 < alu_in2) ? 32'd1 : 32'd0;
      default: alu_result = 32'hDEAD_BEEF;
    endcase
    zero_flag = (alu_result == 32'd0);
  end

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", tag, got, exp, $time);
    end
  endtask

  typedef struct {
    logic        legal;
    logic [2:0]  ctrl;
    logic [31:0] in2;
    logic [31:0] result;
    logic        zero;
    logic [4:0]  rd;
  } exp_t;

  // Instruction-level reference: what the instruction means architecturally.
  function automatic exp_t model(input logic [31:0] ins, input logic [31:0] a,
                                 input logic [31:0] rs2);
    exp_t        e;
    logic [6:0]  op;
    logic [2:0]  f3;
    logic [6:0]  f7;
    logic [31:0] b;
    op = ins[6:0];
    f3 = ins[14:12];
    f7 = ins[31:25];
    b  = (op == 7'h13) ? 32'($signed(ins[31:20])) : rs2;
    e.in2    = b;
    e.rd     = ins[11:7];
    e.legal  = 1'b0;
    e.ctrl   = 3'd0;
    e.result = 32'd0;
    if ((op == 7'h33 && (f7 == 7'h00 || f7 == 7'h20)) || op == 7'h13) begin
      e.legal = 1'b1;
      if (f3 == 3'd0 && op == 7'h33 && f7 == 7'h20) begin
        e.ctrl = 3'd1; e.result = (a > b) ? a - b : b - a;
      end else if (f3 == 3'd0) begin
        e.ctrl = 3'd0; e.result = a + b;
      end else if (f3 == 3'd7) begin
        e.ctrl = 3'd2; e.result = a & b;
      end else if (f3 == 3'd6) begin
        e.ctrl = 3'd3; e.result = a | b;
      end else if (f3 == 3'd4) begin
        e.ctrl = 3'd4; e.result = a ^ b;
      end else if (f3 == 3'd2 || f3 == 3'd3) begin
        e.ctrl = 3'd5; e.result = (a < b) ? 32'd1 : 32'd0;
      end else begin
        e.legal = 1'b0;
      end
    end
    e.zero = e.legal && (e.result == 32'd0);
    return e;
  endfunction

  // Entered at posedge+1 with the DUT idle; returns at posedge+1 with it idle again.
  task automatic run_op(input logic [31:0] ins, input logic [31:0] a, input logic [31:0] b,
                        input int hold);
    exp_t e;
    e = model(ins, a, b);
    check("in_ready_before", 32'(in_ready), 1);
    instr = ins; rs1_val = a; rs2_val = b; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; instr = $urandom; rs1_val = $urandom; rs2_val = $urandom;
`ifdef ALU_ISSUE_PERF_EN
    exp_issued++;
    if (!e.legal) exp_illegal++;
`endif
    if (e.legal) begin
      check("exec_out_valid", 32'(out_valid), 0);
      check("exec_in_ready", 32'(in_ready), 0);
      check("exec_alu_control", 32'(alu_control), 32'(e.ctrl));
      check("exec_alu_in1", alu_in1, a);
      check("exec_alu_in2", alu_in2, e.in2);
      @(posedge clk); #1;
    end
    check("done_out_valid", 32'(out_valid), 1);
    check("done_in_ready", 32'(in_ready), 0);
    check("done_out_illegal", 32'(out_illegal), 32'(!e.legal));
    check("done_out_result", out_result, e.result);
    check("done_out_zero", 32'(out_zero), 32'(e.zero));
    check("done_out_rd", 32'(out_rd), 32'(e.rd));
    check("done_alu_control", 32'(alu_control), 32'(e.ctrl));
`ifdef ALU_ISSUE_PERF_EN
    check("perf_issued", perf_issued, exp_issued);
    check("perf_illegal", perf_illegal, exp_illegal);
`endif
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      check("hold_out_valid", 32'(out_valid), 1);
      check("hold_in_ready", 32'(in_ready), 0);
      check("hold_out_result", out_result, e.result);
      check("hold_out_rd", 32'(out_rd), 32'(e.rd));
    end
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    check("retired_out_valid", 32'(out_valid), 0);
    check("retired_in_ready", 32'(in_ready), 1);
  endtask

  task automatic check_reset_values(input string tag);
    check({tag, "_in_ready"}, 32'(in_ready), 1);
    check({tag, "_out_valid"}, 32'(out_valid), 0);
    check({tag, "_alu_in1"}, alu_in1, 0);
    check({tag, "_alu_in2"}, alu_in2, 0);
    check({tag, "_alu_control"}, 32'(alu_control), 0);
    check({tag, "_out_result"}, out_result, 0);
    check({tag, "_out_zero"}, 32'(out_zero), 0);
    check({tag, "_out_rd"}, 32'(out_rd), 0);
    check({tag, "_out_illegal"}, 32'(out_illegal), 0);
`ifdef ALU_ISSUE_PERF_EN
    check({tag, "_perf_issued"}, perf_issued, 0);
    check({tag, "_perf_illegal"}, perf_illegal, 0);
`endif
  endtask

  initial begin
    logic [31:0] ins, a, b;
    int          pick;
    reset = 1'b1; in_valid = 1'b0; out_ready = 1'b0;
    instr = 32'd0; rs1_val = 32'd0; rs2_val = 32'd0;
    @(posedge clk); @(posedge clk); #1;
    check_reset_values("reset");
    reset = 1'b0;
    @(posedge clk); #1;

    // Directed cases
    run_op(32'h002081B3, 32'd5, 32'd7, 0);           // add
    run_op(32'h402081B3, 32'd5, 32'd7, 0);           // sub -> |5-7|
    run_op(32'h402081B3, 32'd9, 32'd9, 0);           // sub -> 0, zero
    run_op(32'hFFF0C213, 32'h0000000F, 32'd0, 0);    // xori x4,x1,-1
    run_op(32'h002091B3, 32'd3, 32'd4, 0);           // sll: illegal
    run_op(32'h002081B3, 32'd100, 32'd23, 5);        // backpressure
    run_op(32'h0020B1B3, 32'hFFFF_FFFF, 32'd1, 0);   // sltu, unsigned
    run_op(32'h0000D193, 32'd1, 32'd1, 0);           // srli: illegal
    run_op(32'h022081B3, 32'd1, 32'd1, 0);           // funct7 0000001: illegal
    run_op(32'h00000003, 32'd1, 32'd1, 0);           // load opcode: illegal

    // Reset during EXEC drops the instruction
    instr = 32'h002081B3; rs1_val = 32'd1; rs2_val = 32'd2; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0;
    reset = 1'b1;
    #1;
`ifdef ALU_ISSUE_PERF_EN
    exp_issued = 0; exp_illegal = 0;
`endif
    check_reset_values("midreset");
    @(posedge clk); #1;
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(posedge clk); #1;
      check("post_reset_no_valid", 32'(out_valid), 0);
    end
    run_op(32'h002081B3, 32'd5, 32'd7, 1);

    // Randomized instructions
    for (int n = 0; n < 300; n++) begin
      ins  = $urandom;
      pick = $urandom_range(0, 9);
      if (pick < 4)      ins[6:0] = 7'h33;
      else if (pick < 8) ins[6:0] = 7'h13;
      pick = $urandom_range(0, 5);
      if (ins[6:0] == 7'h33 && pick < 3)      ins[31:25] = 7'h00;
      else if (ins[6:0] == 7'h33 && pick < 5) ins[31:25] = 7'h20;
      a = $urandom;
      b = $urandom;
      pick = $urandom_range(0, 3);
      if (pick == 0) b = a;
      else if (pick == 1) begin
        a = 32'($urandom_range(0, 15));
        b = 32'($urandom_range(0, 15));
      end
      run_op(ins, a, b, $urandom_range(0, 3));
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
